// File: rtl/ex_div_if.sv
// ex_div_if: request/response bundle between the EX stage and the iterative divider.
// The EX stage is the master and drives operands and control.
// The divider is the slave and returns the result together with its ready/busy status.
interface ex_div_if;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/ex_div.sv
// ex_div: restoring shift-subtract divider for DIV/DIVU in the EX stage.
// It produces one quotient bit per clock.
// The operands are latched when the request is accepted, so EX may stall with the same instruction presented.
// The result is {remainder, quotient}, with the sign corrected after the 32 magnitude steps.
module ex_div (
    input  logic      clk,
    input  logic      rst,
    ex_div_if.slave   div
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] divisor_r;     // divisor magnitude
    logic [63:0] work_r;        // {partial remainder, dividend/quotient bits}
    logic [5:0]  cnt_r;         // restoring steps completed
    logic        neg_q_r;       // quotient needs negation
    logic        neg_r_r;       // remainder needs negation
    logic [63:0] result_r;
    logic        ready_r;

    logic [64:0] shift_s;       // 65-bit shifted view of the working register
    logic [32:0] diff_s;        // trial difference, bit 32 set when negative
    logic [63:0] work_next_s;
    logic [31:0] quot_fix_s;
    logic [31:0] rem_fix_s;

    // Two's complement negation of a 32-bit value.
    function automatic logic [31:0] neg32_f(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand; negative values are only folded when the division is signed.
    function automatic logic [31:0] mag_f(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            return neg32_f(v);
        end else begin
            return v;
        end
    endfunction

    // One restoring step.
    // Shift left, trial-subtract the divisor from the upper bits, and keep the difference if it did not go negative.
    always_comb begin
        shift_s     = {work_r, 1'b0};
        diff_s      = shift_s[64:32] - {1'b0, divisor_r};
        work_next_s = shift_s[63:0];
        if (!diff_s[32]) begin
            work_next_s = {diff_s[31:0], shift_s[31:1], 1'b1};
        end else begin
            work_next_s = shift_s[63:0];
        end
    end

    // Sign fix-up of the finished magnitudes.
    // With a dividend of 0x80000000 and a divisor of -1, this naturally wraps the quotient to 0x80000000.
    always_comb begin
        quot_fix_s = work_r[31:0];
        rem_fix_s  = work_r[63:32];
        if (neg_q_r) begin
            quot_fix_s = neg32_f(work_r[31:0]);
        end else begin
            quot_fix_s = work_r[31:0];
        end
        if (neg_r_r) begin
            rem_fix_s = neg32_f(work_r[63:32]);
        end else begin
            rem_fix_s = work_r[63:32];
        end
    end

    // Divider FSM: accept, step, complete, and hand off the result until EX releases start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= FREE;
            divisor_r <= 32'd0;
            work_r    <= 64'd0;
            cnt_r     <= 6'd0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            result_r  <= 64'd0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                FREE: begin
                    result_r <= 64'd0;
                    ready_r  <= 1'b0;
                    if (div.start_i && !div.annul_i) begin
                        neg_q_r   <= div.signed_div_i & (div.opdata1_i[31] ^ div.opdata2_i[31]);
                        neg_r_r   <= div.signed_div_i & div.opdata1_i[31];
                        divisor_r <= mag_f(div.opdata2_i, div.signed_div_i);
                        work_r    <= {32'd0, mag_f(div.opdata1_i, div.signed_div_i)};
                        cnt_r     <= 6'd0;
                        if (div.opdata2_i == 32'd0) begin
                            state_r <= BYZERO;
                        end else begin
                            state_r <= ON;
                        end
                    end else begin
                        state_r <= FREE;
                    end
                end
                BYZERO: begin
                    cnt_r <= 6'd0;
                    if (div.annul_i) begin
                        state_r  <= FREE;
                        result_r <= 64'd0;
                        ready_r  <= 1'b0;
                    end else begin
                        state_r  <= END;
                        result_r <= 64'd0;
                        ready_r  <= 1'b1;
                    end
                end
                ON: begin
                    if (div.annul_i) begin
                        state_r  <= FREE;
                        result_r <= 64'd0;
                        ready_r  <= 1'b0;
                        cnt_r    <= 6'd0;
                    end else if (cnt_r == 6'd32) begin
                        state_r  <= END;
                        result_r <= {rem_fix_s, quot_fix_s};
                        ready_r  <= 1'b1;
                    end else begin
                        work_r <= work_next_s;
                        cnt_r  <= cnt_r + 6'd1;
                    end
                end
                END: begin
                    if (!div.start_i) begin
                        state_r  <= FREE;
                        result_r <= 64'd0;
                        ready_r  <= 1'b0;
                    end else begin
                        state_r <= END;
                    end
                end
                default: begin
                    state_r  <= FREE;
                    result_r <= 64'd0;
                    ready_r  <= 1'b0;
                    cnt_r    <= 6'd0;
                end
            endcase
        end
    end

    assign div.result_o = result_r;
    assign div.ready_o  = ready_r;
    assign div.busy_o   = (state_r == ON) || (state_r == BYZERO);

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: randomized and directed checks of ex_div against an arithmetic reference model.
module tb_ex_div;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ex_div_if dif ();

    ex_div dut (
        .clk (clk),
        .rst (rst),
        .div (dif.slave)
    );

    // Reference result {remainder, quotient}, computed with the language's own division operators.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Issue one division, scramble the operands while it runs, check latency, result, hold and release.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string name);
        int lat;
        int exp_lat;
        dif.signed_div_i = sgn;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.annul_i      = 1'b0;
        dif.start_i      = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dif.busy_o !== 1'b1 || dif.ready_o !== 1'b0)
            begin errors++; $display("FAIL %s busy_after_start: busy=%b ready=%b, required busy=1 ready=0", name, dif.busy_o, dif.ready_o); end
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            dif.opdata1_i    = $urandom;
            dif.opdata2_i    = $urandom;
            dif.signed_div_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checks++;
            if (dif.busy_o !== !dif.ready_o)
                begin errors++; $display("FAIL %s busy_ready cycle %0d: busy=%b ready=%b, required exactly one set", name, n, dif.busy_o, dif.ready_o); end
            if (dif.ready_o === 1'b1) begin
                lat = n;
                break;
            end
        end
        exp_lat = (b == 32'd0) ? 1 : 33;
        checks++;
        if (lat != exp_lat)
            begin errors++; $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat); end
        checks++;
        if (dif.result_o !== exp)
            begin errors++; $display("FAIL %s result: got %h, required %h", name, dif.result_o, exp); end
        dif.annul_i = 1'b1;
        @(posedge clk); #1;
        dif.annul_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dif.ready_o !== 1'b1 || dif.busy_o !== 1'b0 || dif.result_o !== exp)
            begin errors++; $display("FAIL %s hold: ready=%b busy=%b result=%h, required ready=1 busy=0 result=%h", name, dif.ready_o, dif.busy_o, dif.result_o, exp); end
        dif.start_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL %s release: ready=%b busy=%b result=%h, required all zero", name, dif.ready_o, dif.busy_o, dif.result_o); end
    endtask

    // Reset values while reset is held and just after it is released.
    task automatic test_reset();
        rst = 1'b0;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i = 32'd0;
        dif.opdata2_i = 32'd0;
        dif.start_i = 1'b0;
        dif.annul_i = 1'b0;
        #12;
        checks++;
        if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL reset_hold: ready=%b busy=%b result=%h, required all zero", dif.ready_o, dif.busy_o, dif.result_o); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL reset_release: ready=%b busy=%b result=%h, required all zero", dif.ready_o, dif.busy_o, dif.result_o); end
    endtask

    // Directed vectors from the worked examples, including overflow and divide by zero.
    task automatic test_directed();
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "u100_7");
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, "s-7_2");
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "s7_-2");
        run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 64'h00000001_7FFFFFFC, "uFFFFFFF9_2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, "s_overflow");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, "uFFFFFFFF_1");
        run_div(1'b0, 32'd1234, 32'd0, 64'd0, "u_div0");
        run_div(1'b1, 32'hFFFF_0000, 32'd0, 64'd0, "s_div0");
    endtask

    // Random operands of mixed sign, size and signedness against the reference model.
    task automatic test_random();
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 300));
                2: b = 32'd0 - 32'($urandom_range(1, 300));
                default: b = (i % 6 == 0) ? 32'd0 : (a >> $urandom_range(0, 31));
            endcase
            run_div(sgn, a, b, ref_div(sgn, a, b), $sformatf("rand%0d", i));
        end
    endtask

    // Cancel at step 10, confirm nothing completes, then a fresh division works.
    task automatic test_annul();
        dif.signed_div_i = 1'b0;
        dif.opdata1_i = 32'd1000;
        dif.opdata2_i = 32'd7;
        dif.start_i = 1'b1;
        dif.annul_i = 1'b0;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL annul_step10: busy=%b ready=%b result=%h, required all zero", dif.busy_o, dif.ready_o, dif.result_o); end
        @(posedge clk); #1;
        checks++;
        if (dif.busy_o !== 1'b0)
            begin errors++; $display("FAIL annul_start_ignored: busy=%b, required 0", dif.busy_o); end
        dif.annul_i = 1'b0;
        dif.start_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            checks++;
            if (dif.ready_o !== 1'b0 || dif.busy_o !== 1'b0)
                begin errors++; $display("FAIL annul_quiet cycle %0d: ready=%b busy=%b, required 0", n, dif.ready_o, dif.busy_o); end
        end
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, "after_annul_9_3");
    endtask

    // Asynchronous reset in the middle of a division and while a result is presented.
    task automatic test_async_reset();
        dif.signed_div_i = 1'b0;
        dif.opdata1_i = 32'd100;
        dif.opdata2_i = 32'd7;
        dif.start_i = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (dif.busy_o !== 1'b0 || dif.ready_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL async_reset_on: busy=%b ready=%b result=%h, required all zero", dif.busy_o, dif.ready_o, dif.result_o); end
        #2;
        rst = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (dif.ready_o === 1'b1) break;
        end
        checks++;
        if (dif.ready_o !== 1'b1 || dif.result_o !== 64'h00000002_0000000E)
            begin errors++; $display("FAIL async_reset_rerun: ready=%b result=%h, required ready=1 result=000000020000000e", dif.ready_o, dif.result_o); end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0)
            begin errors++; $display("FAIL async_reset_end: ready=%b result=%h, required zero", dif.ready_o, dif.result_o); end
        dif.start_i = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, "post_reset_s7_-2");
    endtask

    // Consecutive requests at the minimum spacing.
    task automatic test_back_to_back();
        run_div(1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, "b2b_first");
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7), "b2b_second");
    endtask

    // Sequence all scenarios and print the summary.
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
